// File: rtl/apb_ahb_bridge_pkg.sv
// Shared AHB-Lite encodings and bridge FSM state type for the APB-to-AHB bridge.
// HTRANS_BUSY and HTRANS_SEQ are never issued by this bridge; they complete the encoding set.
package apb_ahb_bridge_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD      = 3'b010;
    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_t;

endpackage

// File: rtl/apb_ahb_bridge.sv
// APB slave to AHB-Lite master bridge: one single-beat word transfer per APB access.
// All AHB and APB outputs come straight from registers updated by a single FSM process.
module apb_ahb_bridge
    import apb_ahb_bridge_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    state_t      state_q;
    logic [31:0] haddr_q;
    logic [31:0] hwdata_q;
    logic [31:0] wdata_q;
    logic [31:0] prdata_q;
    logic [1:0]  htrans_q;
    logic        hwrite_q;
    logic        pready_q;
    logic        pslverr_q;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q   <= ST_IDLE;
            haddr_q   <= '0;
            hwdata_q  <= '0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            htrans_q  <= HTRANS_IDLE;
            hwrite_q  <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            case (state_q)
                // Only a genuine APB setup phase starts a transfer.
                ST_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        haddr_q  <= PADDR & WORD_MASK;
                        hwrite_q <= PWRITE;
                        wdata_q  <= PWDATA;
                        htrans_q <= HTRANS_NONSEQ;
                        state_q  <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        htrans_q <= HTRANS_IDLE;
                        hwdata_q <= wdata_q;
                        state_q  <= ST_DATA;
                    end
                end
                // HRESP with HREADY low is the first half of a two-cycle error: just wait.
                ST_DATA: begin
                    if (HREADY) begin
                        if (!hwrite_q) begin
                            prdata_q <= HRDATA;
                        end
                        pslverr_q <= (HRESP == HRESP_ERROR);
                        pready_q  <= 1'b1;
                        state_q   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HWDATA    = hwdata_q;
    assign PRDATA    = prdata_q;
    assign PREADY    = pready_q;
    assign PSLVERR   = pslverr_q;
    assign HSIZE     = HSIZE_WORD;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA_PRIV;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_apb_ahb_bridge.sv
// Self-checking bench for apb_ahb_bridge: directed and random APB transfers against an AHB slave model.
module tb_apb_ahb_bridge;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_prdata = '0;

    always #5 HCLK = ~HCLK;

    apb_ahb_bridge dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    // One APB access. Entered just after a rising edge with the bridge idle; returns just after
    // the edge that leaves the response cycle. wa/wd = AHB wait states in address/data phase.
    task automatic do_xfer(input string name, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int wa, input int wd, input bit err, input bit drop);
        int          nonseq = 0;
        logic [31:0] exp_haddr;
        exp_haddr = {addr[31:2], 2'b00};
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
        @(negedge HCLK);
        n_cmp++;
        if (PREADY !== 1'b0 || HTRANS !== 2'b00 || PSLVERR !== 1'b0) begin
            n_bad++;
            $display("FAIL %s setup: PREADY=%b HTRANS=%b PSLVERR=%b required 0/00/0", name, PREADY, HTRANS, PSLVERR);
        end
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        if (drop) PSEL = 1'b0;
        for (int i = 0; i <= wa; i++) begin
            HREADY = (i == wa);
            @(negedge HCLK);
            if (HTRANS === 2'b10) nonseq++;
            n_cmp++;
            if (HTRANS !== 2'b10 || HADDR !== exp_haddr || HWRITE !== wr || PREADY !== 1'b0) begin
                n_bad++;
                $display("FAIL %s addr[%0d]: HTRANS=%b HADDR=%h HWRITE=%b PREADY=%b required 10/%h/%b/0",
                         name, i, HTRANS, HADDR, HWRITE, PREADY, exp_haddr, wr);
            end
            @(posedge HCLK); #1;
        end
        if (drop) begin
            PSEL = 1'b1; PENABLE = 1'b0; PADDR = $urandom;
        end
        for (int j = 0; j <= wd; j++) begin
            HREADY = (j == wd);
            HRDATA = (j == wd) ? rdata : $urandom;
            if (err) HRESP = (j + 1 >= wd);
            else     HRESP = (j == wd) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge HCLK);
            if (HTRANS === 2'b10) nonseq++;
            n_cmp++;
            if (HTRANS !== 2'b00 || HWDATA !== wdata || PREADY !== 1'b0 || PSLVERR !== 1'b0) begin
                n_bad++;
                $display("FAIL %s data[%0d]: HTRANS=%b HWDATA=%h PREADY=%b PSLVERR=%b required 00/%h/0/0",
                         name, j, HTRANS, HWDATA, PREADY, PSLVERR, wdata);
            end
            @(posedge HCLK); #1;
        end
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
        if (!wr) exp_prdata = rdata;
        @(negedge HCLK);
        if (HTRANS === 2'b10) nonseq++;
        n_cmp++;
        if (PREADY !== 1'b1 || PSLVERR !== err || PRDATA !== exp_prdata || HTRANS !== 2'b00) begin
            n_bad++;
            $display("FAIL %s resp: PREADY=%b PSLVERR=%b PRDATA=%h HTRANS=%b required 1/%b/%h/00",
                     name, PREADY, PSLVERR, PRDATA, HTRANS, err, exp_prdata);
        end
        n_cmp++;
        if (nonseq != wa + 1) begin
            n_bad++;
            $display("FAIL %s nonseq_count: got %0d required %0d", name, nonseq, wa + 1);
        end
        n_cmp++;
        if (HSIZE !== 3'b010 || HBURST !== 3'b000 || HPROT !== 4'b0011 || HMASTLOCK !== 1'b0) begin
            n_bad++;
            $display("FAIL %s consts: HSIZE=%b HBURST=%b HPROT=%b HMASTLOCK=%b required 010/000/0011/0",
                     name, HSIZE, HBURST, HPROT, HMASTLOCK);
        end
        @(posedge HCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        $display("xfer %s wr=%0b addr=%h wdata=%h rdata=%h wa=%0d wd=%0d err=%0b drop=%0b",
                 name, wr, addr, wdata, rdata, wa, wd, err, drop);
    endtask

    task automatic test_reset;
        #2 HRESET = 1'b1;
        #1;
        n_cmp++;
        if (HTRANS !== 2'b00 || HADDR !== '0 || HWRITE !== 1'b0 || HWDATA !== '0 ||
            PRDATA !== '0 || PREADY !== 1'b0 || PSLVERR !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: HTRANS=%b HADDR=%h HWRITE=%b HWDATA=%h PRDATA=%h PREADY=%b PSLVERR=%b required all 0",
                     HTRANS, HADDR, HWRITE, HWDATA, PRDATA, PREADY, PSLVERR);
        end
        PSEL = 1'b1;
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0; PSEL = 1'b0;
        @(negedge HCLK);
        n_cmp++;
        if (HTRANS !== 2'b00 || PREADY !== 1'b0 || HSIZE !== 3'b010 || HBURST !== 3'b000 ||
            HPROT !== 4'b0011 || HMASTLOCK !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: HTRANS=%b PREADY=%b HSIZE=%b HBURST=%b HPROT=%b HMASTLOCK=%b",
                     HTRANS, PREADY, HSIZE, HBURST, HPROT, HMASTLOCK);
        end
        $display("xfer reset checked");
        @(posedge HCLK); #1;
    endtask

    task automatic test_write_zero_wait;
        do_xfer("write_zero_wait", 1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_read_waits;
        do_xfer("read_3wait", 1'b0, 32'h4000_0020, 32'h0, 32'h1234_5678, 0, 3, 1'b0, 1'b0);
        do_xfer("write_keeps_prdata", 1'b1, 32'h4000_0024, 32'h0BAD_F00D, 32'hFFFF_0000, 0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_error;
        do_xfer("read_error", 1'b0, 32'h5000_0000, 32'h0, 32'hA5A5_5A5A, 0, 1, 1'b1, 1'b0);
        do_xfer("after_error", 1'b0, 32'h5000_0004, 32'h0, 32'h0101_0202, 0, 0, 1'b0, 1'b0);
        do_xfer("write_error", 1'b1, 32'h5000_0008, 32'h7777_8888, 32'h0, 1, 2, 1'b1, 1'b0);
    endtask

    task automatic test_addr_wait;
        do_xfer("addr_wait2", 1'b1, 32'h6000_0100, 32'hCAFE_0001, 32'h0, 2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_unaligned;
        do_xfer("unaligned", 1'b0, 32'h0000_0013, 32'h0, 32'h3C3C_C3C3, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_psel_drop;
        do_xfer("psel_drop", 1'b0, 32'h7000_0040, 32'h0, 32'h5555_AAAA, 1, 2, 1'b0, 1'b1);
        do_xfer("after_drop", 1'b1, 32'h7000_0044, 32'h1357_9BDF, 32'h0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 4; k++) begin
            do_xfer("back_to_back", 1'(k & 1), 32'h8000_0000 + 32'(k * 4), $urandom, $urandom, 0, 0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 30; k++) begin
            int wd_r;
            bit err_r;
            wd_r  = $urandom_range(0, 3);
            err_r = (wd_r >= 1) && ($urandom_range(0, 3) == 0);
            do_xfer("random", 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                    $urandom_range(0, 2), wd_r, err_r, 1'($urandom_range(0, 4) == 0));
        end
    endtask

    task automatic test_reset_mid;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h9000_0010; PWDATA = 32'hFEED_FACE;
        HREADY = 1'b1;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        @(posedge HCLK); #1;
        HREADY = 1'b0;
        #1 HRESET = 1'b1;
        #1;
        n_cmp++;
        if (HTRANS !== 2'b00 || HADDR !== '0 || HWRITE !== 1'b0 || HWDATA !== '0 ||
            PRDATA !== '0 || PREADY !== 1'b0 || PSLVERR !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: HTRANS=%b HADDR=%h HWRITE=%b HWDATA=%h PRDATA=%h PREADY=%b PSLVERR=%b required all 0",
                     HTRANS, HADDR, HWRITE, HWDATA, PRDATA, PREADY, PSLVERR);
        end
        exp_prdata = '0;
        PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        $display("xfer reset_mid checked");
        do_xfer("after_reset", 1'b0, 32'h0000_0004, 32'h0, 32'h89AB_CDEF, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_waits();
        test_error();
        test_addr_wait();
        test_unaligned();
        test_psel_drop();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_ahb_bridge.md
APB_AHB_BRIDGE -- requirements
Module: apb_ahb_bridge

Interface
REQ-001 The block SHALL have one clock and one reset: the clock is HCLK; the reset is HRESET, asynchronous and active-high. The APB side is synchronous to HCLK.
REQ-002 The block SHALL have no parameters; address and data widths are fixed at 32 bits.
REQ-003 Ports SHALL be, as name  direction  width  meaning:
- HCLK  in  1  clock
- HRESET  in  1  async active-high reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  APB write
- PADDR  in  32  APB address
- PWDATA  in  32  APB write data
- PRDATA  out  32  APB read data
- PREADY  out  1  APB ready
- PSLVERR  out  1  APB error
- HADDR  out  32  AHB address
- HTRANS  out  2  AHB transfer type
- HWRITE  out  1  AHB write
- HSIZE  out  3  AHB size
- HBURST  out  3  AHB burst
- HPROT  out  4  AHB protection
- HMASTLOCK  out  1  AHB lock
- HWDATA  out  32  AHB write data
- HRDATA  in  32  AHB read data
- HREADY  in  1  AHB ready
- HRESP  in  1  AHB response, 1 = ERROR

Function
REQ-004 FSM states SHALL be IDLE, ADDR, DATA and RESP, with all AHB outputs driven from registers.
REQ-005 IDLE: when PSEL=1 and PENABLE=0 are sampled, the block SHALL latch PADDR (with [1:0] forced to 00), PWRITE and PWDATA, then go to ADDR.
REQ-006 ADDR: the block SHALL drive HTRANS=NONSEQ(2'b10) and HADDR/HWRITE from the latched values. It SHALL go to DATA on the first edge with HREADY=1 and hold otherwise.
REQ-007 DATA: the block SHALL drive HTRANS=IDLE(2'b00) and HWDATA=latched PWDATA. On the first edge with HREADY=1 it SHALL capture HRDATA into PRDATA and HRESP into an error flag, then go to RESP.
REQ-008 The block SHALL treat two-cycle ERROR (HRESP=1, HREADY=0) as a wait cycle and SHALL NOT cancel the transfer. Only the HRESP value sampled with HREADY=1 counts.
REQ-009 RESP: PREADY SHALL be 1, PSLVERR SHALL equal the captured error, and the block SHALL return to IDLE on the next edge.
REQ-010 PREADY SHALL be 0 in IDLE, ADDR and DATA. PSLVERR SHALL be 0 outside RESP.
REQ-011 With zero-wait AHB, latency SHALL be: setup at T0, NONSEQ at T1, data phase at T2, PREADY=1 at T3.
REQ-012 Constant outputs SHALL be HSIZE=3'b010, HBURST=3'b000, HPROT=4'b0011 and HMASTLOCK=0.
REQ-013 Outside ADDR, HTRANS SHALL be IDLE, and the block SHALL never issue back-to-back NONSEQ.
REQ-014 If PSEL drops mid-transfer, the block SHALL still complete the AHB transfer, pass through RESP and return to IDLE. No new transfer SHALL start before IDLE.
REQ-015 PRDATA SHALL hold its last captured value until the next read completes. A write SHALL leave PRDATA unchanged.

Reset
REQ-016 While HRESET=1, the block SHALL force state=IDLE, HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, PRDATA=0, PREADY=0 and PSLVERR=0, independent of HCLK.
REQ-017 Reset asserted mid-transfer SHALL abandon the transfer immediately. After reset release, the first sampled setup phase SHALL start a fresh transfer.

Structure
REQ-018 HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ), HSIZE word and HRESP codes SHALL live in the shared AHB utility include. The APB port list SHALL use the shared APB slave interface macro.
REQ-019 The block SHALL be a single flat module with no sub-module.

Verification
REQ-020 Write, zero-wait: PADDR=0x4000_0010, PWDATA=0xDEAD_BEEF -> NONSEQ at T1 with HADDR=0x4000_0010 and HWRITE=1; HWDATA=0xDEAD_BEEF at T2; PREADY=1 and PSLVERR=0 at T3.
REQ-021 Read with 3 HREADY wait states in the data phase, HRDATA=0x1234_5678 -> PREADY=1 exactly at T6 with PRDATA=0x1234_5678.
REQ-022 Two-cycle ERROR on a read -> PSLVERR=1 together with PREADY=1 in RESP; the next transfer returns PSLVERR=0.
REQ-023 HREADY=0 for 2 cycles during ADDR -> HTRANS stays NONSEQ and HADDR stays stable; NONSEQ is never re-issued.
REQ-024 HRESET pulsed during DATA -> all outputs equal their reset values within the same cycle; the following transfer to 0x0000_0004 completes normally.
REQ-025 PADDR=0x0000_0013 -> HADDR=0x0000_0010.
